ras: RTL

- Return Address Stack for the fetch predictor path.
- Sits beside the BTB/UPCT lookup in fetch. It is pushed on predicted calls and popped on predicted returns, and it supplies the predicted return target to the fetch PC mux.
- The top-of-stack index and occupancy are exported so the checkpoint array can save them per branch. The decode/ROB mispredict path restores them.
- Circular, overwrite-oldest on overflow; pointer-restore only (entry contents are not restored).

---
 rtl/ras_pkg.sv | 16 +
 rtl/ras.sv | 80 ++++++++
 2 files changed

// File: rtl/ras_pkg.sv
// Shared constants and the per-cycle operation decode for the return address stack.
package ras_pkg;

  localparam int unsigned RAS_ENTRIES      = 8;
  localparam int unsigned RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES);
  localparam int unsigned RAS_TARGET_WIDTH = 31;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_POP,
    OP_PUSH,
    OP_SWAP,
    OP_RESTORE
  } ras_op_e;

endpackage

// File: rtl/ras.sv
// Return address stack: circular flop array with overwrite-oldest on overflow,
// pointer/occupancy export for checkpointing and pointer-only restore.
module ras #(
  parameter int unsigned RAS_ENTRIES      = ras_pkg::RAS_ENTRIES,
  parameter int unsigned RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES),
  parameter int unsigned RAS_TARGET_WIDTH = ras_pkg::RAS_TARGET_WIDTH
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        push_valid,
  input  logic [RAS_TARGET_WIDTH-1:0] push_address,
  input  logic                        pop_valid,
  input  logic                        update_valid,
  input  logic [RAS_INDEX_WIDTH-1:0]  update_ras_index,
  input  logic [RAS_INDEX_WIDTH:0]    update_ras_count,
  output logic [RAS_TARGET_WIDTH-1:0] pop_target,
  output logic                        pop_empty,
  output logic [RAS_INDEX_WIDTH-1:0]  ras_index,
  output logic [RAS_INDEX_WIDTH:0]    ras_count
);
  import ras_pkg::*;

  localparam int unsigned          CNT_W    = RAS_INDEX_WIDTH + 1;
  localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(RAS_ENTRIES);

  logic [RAS_TARGET_WIDTH-1:0] mem [RAS_ENTRIES];
  logic [RAS_INDEX_WIDTH-1:0]  top_index;
  logic [RAS_INDEX_WIDTH-1:0]  top_inc;
  logic [RAS_INDEX_WIDTH-1:0]  top_dec;
  logic [CNT_W-1:0]            count;
  ras_op_e                     op;

  // Power-of-two depth lets the pointer wrap naturally in both directions.
  assign top_inc = top_index + RAS_INDEX_WIDTH'(1);
  assign top_dec = top_index - RAS_INDEX_WIDTH'(1);

  always_comb begin
    op = OP_IDLE;
    if (update_valid)                  op = OP_RESTORE;
    else if (push_valid && pop_valid)  op = OP_SWAP;
    else if (push_valid)               op = OP_PUSH;
    else if (pop_valid && count != '0) op = OP_POP;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mem       <= '{default: '0};
      top_index <= '0;
      count     <= '0;
    end else begin
      unique case (op)
        OP_RESTORE: begin
          top_index <= update_ras_index;
          count     <= (update_ras_count > CNT_FULL) ? CNT_FULL : update_ras_count;
        end
        OP_SWAP: begin
          // Coroutine swap replaces the top in place; pointer stays put.
          mem[top_index] <= push_address;
          if (count == '0) count <= CNT_W'(1);
        end
        OP_PUSH: begin
          mem[top_inc] <= push_address;
          top_index    <= top_inc;
          if (count != CNT_FULL) count <= count + CNT_W'(1);
        end
        OP_POP: begin
          top_index <= top_dec;
          count     <= count - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign pop_target = mem[top_index];
  assign pop_empty  = (count == '0);
  assign ras_index  = top_index;
  assign ras_count  = count;

endmodule
